// File: rtl/draw_sprite_if.sv
// vga_if: VGA timing and colour bundle passed between pipeline stages (rev 1.0).
`default_nettype none

interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport IN  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport OUT (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

`default_nettype wire

// File: rtl/draw_sprite.sv
// draw_sprite: overlays an SPR_W x SPR_H ROM image on the VGA stream at a
// frame-latched position; opaque, colour-keyed and blinking modes (rev 1.0).
`default_nettype none

module draw_sprite #(
  parameter int          SPR_W        = 64,
  parameter int          SPR_H        = 48,
  parameter int          ROM_LAT      = 1,
  parameter logic [11:0] KEY_COLOR    = 12'h000,
  parameter int          BLINK_FRAMES = 30,
  localparam int         COL_W        = $clog2(SPR_W),
  localparam int         ROW_W        = $clog2(SPR_H),
  localparam int         AW           = COL_W + ROW_W
) (
  input  logic          clk,
  input  logic          rst,
  vga_if.IN             in,
  vga_if.OUT            out,
  input  logic [11:0]   xpos,
  input  logic [11:0]   ypos,
  input  logic [1:0]    mode,
  input  logic [11:0]   rgb_pixel,
  output logic [AW-1:0] rgb_address
);
  localparam int CNT_W = $clog2(BLINK_FRAMES + 1);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
    logic        hit;
    logic        keyed;
    logic        visible;
  } stage_t;

  logic [11:0]          xs;
  logic [11:0]          ys;
  logic [1:0]           mode_s;
  logic                 prev_vblnk;
  logic [CNT_W-1:0]     frame_cnt;
  logic                 blink_on;
  logic                 vblnk_rise;
  logic [12:0]          hc;
  logic [12:0]          vc;
  logic [12:0]          dx;
  logic [12:0]          dy;
  logic                 hit;
  stage_t               cur;
  stage_t [ROM_LAT-1:0] pipe;
  stage_t               last;
  logic                 draw;
  logic [11:0]          rgb_nxt;

  assign vblnk_rise = in.vblnk && !prev_vblnk;

  // Shadow registers and blink counter only move on a vblnk rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs         <= '0;
      ys         <= '0;
      mode_s     <= 2'b00;
      prev_vblnk <= 1'b0;
      frame_cnt  <= '0;
      blink_on   <= 1'b1;
    end else begin
      prev_vblnk <= in.vblnk;
      if (vblnk_rise) begin
        xs     <= xpos;
        ys     <= ypos;
        mode_s <= mode;
        if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink_on  <= !blink_on;
        end else begin
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
      end
    end
  end

  // 13-bit compare so xs + SPR_W never wraps back to column 0.
  always_comb begin
    hc  = {2'b00, in.hcount};
    vc  = {2'b00, in.vcount};
    dx  = hc - {1'b0, xs};
    dy  = vc - {1'b0, ys};
    hit = (hc >= {1'b0, xs}) && (hc < ({1'b0, xs} + 13'(SPR_W))) &&
          (vc >= {1'b0, ys}) && (vc < ({1'b0, ys} + 13'(SPR_H))) &&
          !in.hblnk && !in.vblnk && (mode_s != 2'b00);
  end

  generate
    if (ROW_W > 0) begin : g_row
      logic unused_hi;
      assign unused_hi   = &{1'b0, dx[12:COL_W], dy[12:ROW_W]};
      assign rgb_address = hit ? {dy[ROW_W-1:0], dx[COL_W-1:0]} : '0;
    end else begin : g_norow
      logic unused_hi;
      assign unused_hi   = &{1'b0, dx[12:COL_W], dy};
      assign rgb_address = hit ? dx[COL_W-1:0] : '0;
    end
  endgenerate

  always_comb begin
    cur         = '0;
    cur.hcount  = in.hcount;
    cur.vcount  = in.vcount;
    cur.hsync   = in.hsync;
    cur.vsync   = in.vsync;
    cur.hblnk   = in.hblnk;
    cur.vblnk   = in.vblnk;
    cur.rgb     = in.rgb;
    cur.hit     = hit;
    cur.keyed   = mode_s[1];
    cur.visible = (mode_s != 2'b11) || blink_on;
  end

  // Delay line matches the ROM read latency so each entry meets its rgb_pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= cur;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  always_comb begin
    last    = pipe[ROM_LAT-1];
    draw    = last.hit && last.visible && !(last.keyed && (rgb_pixel == KEY_COLOR));
    rgb_nxt = draw ? rgb_pixel : last.rgb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.hcount <= last.hcount;
      out.vcount <= last.vcount;
      out.hsync  <= last.hsync;
      out.vsync  <= last.vsync;
      out.hblnk  <= last.hblnk;
      out.vblnk  <= last.vblnk;
      out.rgb    <= rgb_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_draw_sprite.sv
// tb_draw_sprite: randomized and directed bench for draw_sprite with a pixel-level reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_draw_sprite;
  localparam int          SPR_W   = 64;
  localparam int          SPR_H   = 48;
  localparam int          ROM_LAT = 2;
  localparam int          BF      = 2;
  localparam logic [11:0] KEY     = 12'h000;
  localparam int          AW      = $clog2(SPR_W) + $clog2(SPR_H);
  localparam int          LAG     = ROM_LAT + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [11:0]   xpos = '0;
  logic [11:0]   ypos = '0;
  logic [1:0]    mode = '0;
  logic [11:0]   rgb_pixel;
  logic [AW-1:0] rgb_address;

  vga_if vin ();
  vga_if vout ();

  always #5 clk = ~clk;

  draw_sprite #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .ROM_LAT(ROM_LAT),
    .KEY_COLOR(KEY), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .in(vin), .out(vout),
    .xpos(xpos), .ypos(ypos), .mode(mode),
    .rgb_pixel(rgb_pixel), .rgb_address(rgb_address)
  );

  // Image ROM with ROM_LAT cycles of read latency.
  int            rom_sel = 0;
  logic [AW-1:0] apipe [ROM_LAT];

  function automatic logic [11:0] rom_fn(int a, int sel);
    if (sel == 0) return 12'(a + 1);
    return ((a % SPR_W) < 32) ? 12'h000 : 12'hd33;
  endfunction

  always @(posedge clk) begin
    apipe[0] <= rgb_address;
    for (int i = 1; i < ROM_LAT; i++) apipe[i] <= apipe[i-1];
  end

  always_comb rgb_pixel = rom_fn(int'(apipe[ROM_LAT-1]), rom_sel);

  // Reference state: what the sprite settings are for the current frame.
  int   m_xs, m_ys, m_mode, m_rises;
  bit   m_prev;
  int   errors = 0;
  int   checks = 0;
  logic [38:0] expq [$];
  logic [11:0] last_obs;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [38:0] outv();
    return {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
  endfunction

  task automatic step(int hc, int vc, bit hs, bit vs, bit hb, bit vb, logic [11:0] bg);
    logic [38:0] e;
    int          a;
    bit          hit, vis, drw;
    logic [11:0] pix;
    @(posedge clk);
    #1;
    e = expq.pop_front();
    check("out", outv(), e);
    last_obs = vout.rgb;
    vin.hcount = 11'(hc);
    vin.vcount = 11'(vc);
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = bg;
    #1;
    hit = (hc >= m_xs) && (hc < m_xs + SPR_W) && (vc >= m_ys) && (vc < m_ys + SPR_H) &&
          !hb && !vb && (m_mode != 0);
    a   = hit ? (vc - m_ys) * SPR_W + (hc - m_xs) : 0;
    check("addr", 64'(rgb_address), 64'(a));
    pix = rom_fn(a, rom_sel);
    vis = (m_mode != 3) || (((m_rises / BF) % 2) == 0);
    drw = hit && vis && !((m_mode >= 2) && (pix == KEY));
    expq.push_back({11'(hc), 11'(vc), hs, vs, hb, vb, drw ? pix : bg});
    if (vb && !m_prev) begin
      m_xs = int'(xpos);
      m_ys = int'(ypos);
      m_mode = int'(mode);
      m_rises++;
    end
    m_prev = vb;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
    #1;
    check("rst_out", 64'(outv()), 64'd0);
    check("rst_addr", 64'(rgb_address), 64'd0);
    repeat (n) @(posedge clk);
    #1;
    check("rst_hold", 64'(outv()), 64'd0);
    rst = 1'b0;
    expq.delete();
    repeat (LAG) expq.push_back('0);
    m_xs = 0; m_ys = 0; m_mode = 0; m_rises = 0; m_prev = 1'b0;
  endtask

  task automatic new_frame(int x, int y, int m);
    xpos = 12'(x);
    ypos = 12'(y);
    mode = 2'(m);
    step(0, 0, 0, 0, 1, 0, 12'h000);
    step(0, 0, 0, 1, 1, 1, 12'h000);
    step(0, 0, 0, 1, 1, 1, 12'h000);
    step(0, 0, 0, 0, 1, 0, 12'h000);
  endtask

  task automatic probe(string tag, int hc, int vc, bit hb, logic [11:0] bg, logic [11:0] exp);
    step(hc, vc, 0, 0, hb, 0, bg);
    repeat (LAG) step(0, 0, 0, 0, 1, 0, 12'h5a5);
    check(tag, 64'(last_obs), 64'(exp));
  endtask

  initial begin
    int cnt, x, y, m, hc, vc;
    #2;
    do_reset(5);

    // Opaque mode, boundary pixels
    rom_sel = 0;
    new_frame(100, 50, 1);
    probe("opq_tl", 100, 50, 0, 12'h777, 12'h001);
    probe("opq_br", 163, 97, 0, 12'h777, 12'hc00);
    probe("opq_right", 164, 50, 0, 12'h777, 12'h777);
    probe("opq_below", 100, 98, 0, 12'h777, 12'h777);
    probe("opq_left", 99, 50, 0, 12'h777, 12'h777);

    // Pixel count over a window one pixel larger than the sprite on every side
    repeat (LAG) step(0, 0, 0, 0, 1, 0, 12'hfff);
    cnt = 0;
    for (int v = 49; v <= 98; v++)
      for (int h = 99; h <= 164; h++) begin
        step(h, v, 0, 0, 0, 0, 12'hfff);
        if (last_obs != 12'hfff) cnt++;
      end
    repeat (LAG) begin
      step(0, 0, 0, 0, 1, 0, 12'hfff);
      if (last_obs != 12'hfff) cnt++;
    end
    check("opq_count", 64'(cnt), 64'd3072);

    // Colour key
    rom_sel = 1;
    new_frame(100, 50, 2);
    probe("key_left", 110, 60, 0, 12'habc, 12'habc);
    probe("key_right", 140, 60, 0, 12'habc, 12'hd33);
    new_frame(100, 50, 1);
    probe("opq_left_black", 110, 60, 0, 12'habc, 12'h000);

    // Tear-free position update
    rom_sel = 0;
    new_frame(100, 50, 1);
    probe("tear_old", 100, 60, 0, 12'h123, 12'h281);
    xpos = 12'd300;
    probe("tear_hold", 100, 60, 0, 12'h123, 12'h281);
    probe("tear_nonew", 300, 60, 0, 12'h123, 12'h123);
    new_frame(300, 50, 1);
    probe("tear_new", 300, 60, 0, 12'h123, 12'h281);
    probe("tear_gone", 100, 60, 0, 12'h123, 12'h123);

    // Randomized frames against the reference model
    for (int f = 0; f < 6; f++) begin
      repeat (LAG) step(0, 0, 0, 0, 1, 0, 12'h000);
      rom_sel = int'($urandom_range(0, 1));
      x = int'($urandom_range(0, 1060));
      y = int'($urandom_range(0, 520));
      m = int'($urandom_range(0, 3));
      new_frame(x, y, m);
      for (int p = 0; p < 400; p++) begin
        hc = x - 8 + int'($urandom_range(0, SPR_W + 16));
        vc = y - 8 + int'($urandom_range(0, SPR_H + 16));
        if (hc < 0) hc = 0;
        if (vc < 0) vc = 0;
        step(hc, vc, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0), 0, 12'($urandom));
      end
    end

    // Mid-frame reset, then blink
    repeat (LAG) step(0, 0, 0, 0, 1, 0, 12'h000);
    rom_sel = 0;
    new_frame(200, 100, 1);
    for (int h = 200; h < 210; h++) step(h, 110, 0, 0, 0, 0, 12'h0f0);
    do_reset(4);
    probe("rst_sprite_off", 210, 110, 0, 12'h0f0, 12'h0f0);
    for (int k = 1; k <= 8; k++) begin
      new_frame(200, 100, 3);
      probe($sformatf("blink_f%0d", k), 210, 110, 0, 12'h0f0,
            (((k / BF) % 2) == 0) ? 12'h28b : 12'h0f0);
    end

    // Right-edge clipping and blanking
    new_frame(1000, 470, 1);
    probe("clip_last", 1023, 480, 0, 12'h444, 12'h298);
    probe("clip_before", 999, 480, 0, 12'h444, 12'h444);
    probe("clip_col0", 0, 480, 0, 12'h444, 12'h444);
    probe("clip_hblnk", 1010, 480, 1, 12'h444, 12'h444);
    repeat (LAG) step(0, 0, 0, 0, 1, 0, 12'hfff);
    cnt = 0;
    for (int h = 0; h <= 1040; h++) begin
      step(h, 480, 0, 0, (h >= 1024), 0, 12'hfff);
      if (last_obs != 12'hfff) cnt++;
    end
    repeat (LAG) begin
      step(0, 0, 0, 0, 1, 0, 12'hfff);
      if (last_obs != 12'hfff) cnt++;
    end
    check("clip_count", 64'(cnt), 64'd24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/draw_sprite.md
# draw_sprite

Parametrised sprite overlay stage for the VGA pipeline, successor to the fixed rectangle drawer. It sits between the background/timing stages and the VGA output. It overlays an SPR_W×SPR_H image, fetched from an external image ROM with configurable read latency, at a frame-latched position. Mode select provides opaque, colour-keyed (transparent) and blinking drawing, and all timing signals stay aligned to the delayed pixel data.

## Interface
- SPR_W, 64: sprite width in pixels; power of two, 2..256.
- SPR_H, 48: sprite height in pixels; 1..256.
- ROM_LAT, 1: clock cycles from `rgb_address` to valid `rgb_pixel`; 1..4.
- KEY_COLOR, 12'h0_0_0: transparent colour in keyed and blink modes.
- BLINK_FRAMES, 30: frames per blink half-period; ≥1.
- clk  in  1  pixel clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- in  vga_if.IN  -  upstream timing and colour: hcount/vcount 11 b, hsync/vsync/hblnk/vblnk 1 b, rgb 12 b.
- out  vga_if.OUT  -  downstream timing and colour, same fields.
- xpos, ypos  in  12 each  requested sprite top-left corner.
- mode  in  2  00 off, 01 opaque, 10 keyed, 11 blink.
- rgb_pixel  in  12  ROM data for the address issued ROM_LAT cycles earlier.
- rgb_address  out  AW = log2(SPR_W) + ceil(log2(SPR_H))  {row, col} into the ROM.

## Operation
- **Frame latch.** On a rising edge of in.vblnk, detected with a registered copy of the previous value, xpos, ypos and mode are copied into shadow registers. Only the shadow values are used for drawing, so a frame never tears.
- **Hit test.** Computed combinationally on `in`, in 13-bit unsigned arithmetic so there is no wrap:
  - hit = (hcount ≥ xs) && (hcount < xs+SPR_W) && (vcount ≥ ys) && (vcount < ys+SPR_H) && !hblnk && !vblnk && (mode_s ≠ 00).
  - Bounds are half-open, so the sprite covers exactly SPR_W×SPR_H pixels.
  - A sprite partly off-screen is clipped naturally.
- **Address.**
  - col = hcount−xs, truncated to log2(SPR_W) bits.
  - row = vcount−ys, truncated to ceil(log2(SPR_H)) bits.
  - rgb_address = {row, col} when hit, otherwise 0. It is combinational from `in` and the shadow registers.
- **Delay line.** A ROM_LAT-stage register pipeline carries the following, so that each entry arrives together with its rgb_pixel:
  - hcount, vcount, hsync, vsync, hblnk, vblnk
  - in.rgb
  - hit
  - the keyed flag (mode_s is 10 or 11)
  - the visible flag (mode_s ≠ 11, or blink_on)
- **Colour select**, using the delayed values:
  - draw = hit_d && visible_d && !(keyed_d && rgb_pixel == KEY_COLOR).
  - rgb_nxt = draw ? rgb_pixel : rgb_d.
- **Output.** out is registered: all timing fields come from the last delay stage, and out.rgb takes rgb_nxt.
- **Blink counter.**
  - frame_cnt counts rising edges of in.vblnk, from 0 to BLINK_FRAMES−1.
  - When it wraps to 0, blink_on toggles.
  - The counter runs in every mode.

## Timing
- Latency from in to out is ROM_LAT+1 cycles for every field. The timing relationship between fields is preserved exactly.
- Reset values, applied asynchronously:
  - all out fields 0
  - all delay stages 0
  - shadow xs, ys = 0 and mode_s = 00, so the block is a pass-through in the first frame
  - frame_cnt = 0, blink_on = 1
  - prev_vblnk = 0
  - rgb_address is 0 while rst is high, because mode_s = 00 forces hit = 0.
- During the first ROM_LAT+1 cycles after reset release, out carries the reset zeros.
- A change in xpos, ypos or mode mid-frame has no effect until the next vblnk rising edge, and takes effect from the first visible line of that frame.
- If a vblnk rising edge and a wrap of frame_cnt occur in the same cycle, the shadow registers take the new mode and blink_on toggles. The new values apply together from the next frame.
- If reset is asserted mid-frame, all state clears immediately. Output resumes ROM_LAT+1 cycles after release, and the sprite is off until the next vblnk edge.
- xs+SPR_W > 1023 is legal: the sprite is clipped at the right edge and nothing wraps to column 0.

## Test plan
- **Reset and latency.** Use the default parameters (SPR_W=64, SPR_H=48) with ROM_LAT=2. Hold rst high for 5 cycles, then release. Required: out is all zeros until 3 cycles after release, and afterwards out.hcount equals in.hcount from 3 cycles earlier. Repeat with ROM_LAT=1 (lag 2) and ROM_LAT=4 (lag 5).
- **Opaque bounds.**
  - Setup: xpos=100, ypos=50, mode=01, applied before vblnk; ROM model returns address+1.
  - Required at pixel (100,50): out.rgb = 12'h001.
  - Required at (163,97): out.rgb = {6'd47, 6'd63}+1.
  - Required at (164,50) and (100,98): out.rgb is the background.
  - Exactly 3072 pixels are replaced per frame.
- **Colour key.** With mode=10, the ROM returns 12'h000 for col<32 and 12'hd33 otherwise. Required: the left half of the sprite shows the background and the right half shows 12'hd33. The same ROM with mode=01 shows 12'h000 on the left half.
- **Tear-free update.** Change xpos from 100 to 300 at vcount=200. Required: the current frame still draws at x=100, and the next frame draws at x=300.
- **Blink.** Set BLINK_FRAMES=2 and mode=11, and run 8 frames. Required: the sprite is visible in frames 0–1, hidden in 2–3, visible in 4–5 and hidden in 6–7.
- **Clipping and blanking.** Set xpos=1000 and ypos=470 on a 1024×768 timing. Required: only columns 1000..1023 are drawn and no pixel appears at column 0. During hblnk or vblnk, out.rgb equals the delayed in.rgb.
